// File: rtl/rv_data_memory.sv
// rv_data_memory: byte-addressed little-endian data RAM, sync write, comb read, lane enables, wrapping unaligned access
module rv_data_memory #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [3:0]            byte_enable,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data
);
  localparam int AW = $clog2(DEPTH_BYTES);
  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] lane_addr [4];
  logic          unused_upper;
  assign unused_upper = ^address[ADDR_WIDTH-1:AW];
  // lane addresses are AW bits wide, so the sum wraps past the top byte to byte 0
  always_comb
    for (int i = 0; i < 4; i++) lane_addr[i] = address[AW-1:0] + AW'(i);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int k = 0; k < DEPTH_BYTES; k++) mem[k] <= '0;
    end else if (write_enable) begin
      for (int i = 0; i < 4; i++)
        if (byte_enable[i]) mem[lane_addr[i]] <= write_data[8*i +: 8];
    end
  always_comb begin
    read_data = '0;
    for (int i = 0; i < 4; i++)
      read_data[8*i +: 8] = (read_enable && byte_enable[i] && !reset) ? mem[lane_addr[i]] : 8'h00;
  end
endmodule

// File: tb/tb_rv_data_memory.sv
// tb_rv_data_memory: directed self-checking bench for rv_data_memory
module tb_rv_data_memory;
  logic        clk = 0;
  logic        reset = 1;
  logic        write_enable = 0;
  logic        read_enable = 0;
  logic [31:0] address = '0;
  logic [3:0]  byte_enable = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  int checks = 0;
  int fails = 0;

  rv_data_memory dut (
    .clk(clk), .reset(reset), .write_enable(write_enable), .read_enable(read_enable),
    .address(address), .byte_enable(byte_enable), .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (read_data === exp) else begin
      fails++;
      $error("FAIL %s: read_data=%h expected=%h", tag, read_data, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    read_enable = 0; address = a; byte_enable = be; write_data = d; write_enable = 1;
    @(posedge clk);
    #1 write_enable = 0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] exp);
    write_enable = 0; read_enable = 1; address = a; byte_enable = be;
    #1 check(tag, exp);
  endtask

  initial begin
    read_enable = 1; byte_enable = 4'hF;
    #3 check("during_reset", 32'h0);
    #9 reset = 0;
    rd("reset_state", 0, 4'hF, 32'h0);
    wr(3, 4'b0001, 32'h5);
    rd("byte3_be1", 3, 4'b0001, 32'h00000005);
    rd("byte3_bef", 3, 4'hF, 32'h00000005);
    rd("byte3_from2", 2, 4'hF, 32'h00000500);
    wr(0, 4'hF, 32'hDEADBEEF);
    rd("word", 0, 4'hF, 32'hDEADBEEF);
    rd("lane0", 0, 4'b0001, 32'h000000EF);
    rd("mid_lanes", 0, 4'b0110, 32'h00ADBE00);
    rd("unaligned", 1, 4'hF, 32'h00DEADBE);
    wr(1, 4'b0001, 32'h000000AA);
    rd("partial", 0, 4'hF, 32'hDEADAAEF);
    @(negedge clk);
    read_enable = 0; address = 0; byte_enable = 4'hF;
    #1 check("re_off", 32'h0);
    write_data = 32'h12345678;
    @(posedge clk);
    #1 rd("we_off", 0, 4'hF, 32'hDEADAAEF);
    wr(0, 4'b0000, 32'h12345678);
    rd("be_zero", 0, 4'hF, 32'hDEADAAEF);
    @(negedge clk);
    address = 8; byte_enable = 4'hF; write_data = 32'hCAFEF00D; write_enable = 1; read_enable = 1;
    #1 check("rw_old", 32'h0);
    @(posedge clk);
    #1 check("rw_new", 32'hCAFEF00D);
    write_enable = 0;
    wr(1023, 4'hF, 32'h44332211);
    rd("wrap_read", 1023, 4'hF, 32'h44332211);
    rd("wrap_low", 0, 4'hF, 32'hDE443322);
    rd("top_byte", 1023, 4'b0001, 32'h00000011);
    rd("upper_ignored", 32'h00000400, 4'hF, 32'hDE443322);
    @(negedge clk);
    #2 reset = 1;
    #1 check("reset_mid", 32'h0);
    #1 reset = 0;
    rd("after_reset0", 0, 4'hF, 32'h0);
    rd("after_reset8", 8, 4'hF, 32'h0);
    rd("after_reset_top", 1023, 4'hF, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
